// File: rtl/aes128_req_sched.sv
// Round-robin scheduler feeding N requesters into one fully pipelined AES-128 core.
// Credit-gated response FIFO. Optional counters are enabled by AES128_SCHED_STATS_EN.
module aes128_req_sched #(
    parameter int N       = 2,
    parameter int IDW     = 1,
    parameter int LATENCY = 21,
    parameter int DEPTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*128-1:0]   req_state,
    input  logic [N*128-1:0]   req_key,
    output logic [127:0]       core_state,
    output logic [127:0]       core_key,
    input  logic [127:0]       core_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [127:0]       rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy
`ifdef AES128_SCHED_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_stall
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int VW = 1 << IDW;

    logic [IDW-1:0]   last_ptr_q, last_ptr_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             vld_q [LATENCY];
    logic [IDW-1:0]   id_q  [LATENCY];
    logic [IDW+127:0] mem_q [DEPTH];
    logic [IDW+127:0] head;

    logic [VW-1:0]    valid_pad;
    logic             found, can_issue, issue, pop, wr_en;
    logic [IDW-1:0]   grant_idx;

    assign valid_pad = VW'(req_valid);

    // Cyclic search starting one past the last granted requester.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        logic [IDW:0] cand;
        cand      = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
            if (!found && valid_pad[cand[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    assign can_issue = (credit_q < CW'(DEPTH));
    assign issue     = found && can_issue && !rst;
    assign req_ready = issue ? (N'(1) << grant_idx) : '0;

    always_comb begin
        core_state = '0;
        core_key   = '0;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                core_state = req_state[128*i +: 128];
                core_key   = req_key[128*i +: 128];
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign rsp_valid = !rst && (count_q != '0);
    assign rsp_data  = head[127:0];
    assign rsp_id    = head[IDW+127:128];
    assign busy      = !rst && (credit_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign wr_en     = vld_q[LATENCY-1];

    always_comb begin
        last_ptr_d = issue ? grant_idx : last_ptr_q;
        credit_d   = credit_q;
        count_d    = count_q;
        case ({issue, pop})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr_q <= IDW'(N-1);
            credit_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
        end else begin
            last_ptr_q <= last_ptr_d;
            credit_q   <= credit_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            vld_q[0]   <= issue;
            for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // NOTE: IDs and FIFO storage carry no reset; the valid bits and pointers qualify them.
    always_ff @(posedge clk) begin
        id_q[0] <= grant_idx;
        for (int i = 1; i < LATENCY; i++) id_q[i] <= id_q[i-1];
        if (wr_en) mem_q[wr_ptr_q] <= {id_q[LATENCY-1], core_out};
    end

`ifdef AES128_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (issue && stat_issued_q != 32'hFFFF_FFFF) stat_issued_q <= stat_issued_q + 32'd1;
            if ((|req_valid) && credit_q == CW'(DEPTH) && stat_stall_q != 32'hFFFF_FFFF)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_aes128_req_sched.sv
// Bench for aes128_req_sched: behavioural AES core model, timestamped response-queue reference,
// directed scenarios and random traffic. Stats checks apply when AES128_SCHED_STATS_EN is defined.
module tb_aes128_req_sched;
    localparam int N       = 2;
    localparam int IDW     = 1;
    localparam int LATENCY = 21;
    localparam int DEPTH   = 32;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid, req_ready;
    logic [N*128-1:0]   req_state, req_key;
    logic [127:0]       core_state, core_key, core_out;
    logic               rsp_valid, rsp_ready, busy;
    logic [127:0]       rsp_data;
    logic [IDW-1:0]     rsp_id;
`ifdef AES128_SCHED_STATS_EN
    logic [31:0]        stat_issued, stat_stall;
`endif

    aes128_req_sched #(.N(N), .IDW(IDW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_key(req_key),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef AES128_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] w [4];
        logic [7:0] rcon;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rcon = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w[0] = sbox_t[k[13]] ^ rcon;
            w[1] = sbox_t[k[14]];
            w[2] = sbox_t[k[15]];
            w[3] = sbox_t[k[12]];
            for (int i = 0; i < 4; i++)  k[i] = k[i] ^ w[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rcon = xt(rcon);
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Pipelined core: sampled at the edge, result appears LATENCY edges later.
    logic [127:0] core_pipe [LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= aes_enc(core_state, core_key);
        for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LATENCY-1];

    // ---------------- Reference model: timestamped queue of outstanding blocks ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [127:0]   data;
        int             avail;
    } exp_t;

    exp_t mq[$];
    int   m_last  = N - 1;
    int   cyc     = 0;
    int   m_iss   = 0;
    int   m_stall = 0;

    always @(negedge clk) begin
        logic         eg, erv;
        int           egi;
        logic [N-1:0] eready;
        logic [127:0] es, ek;
        eg  = 1'b0;
        egi = 0;
        for (int k = 1; k <= N; k++) begin
            int cidx;
            cidx = (m_last + k) % N;
            if (!eg && !rst && mq.size() < DEPTH && req_valid[cidx]) begin
                eg  = 1'b1;
                egi = cidx;
            end
        end
        eready = eg ? (N'(1) << egi) : '0;
        es     = eg ? req_state[128*egi +: 128] : '0;
        ek     = eg ? req_key[128*egi +: 128] : '0;
        erv    = !rst && mq.size() > 0 && mq[0].avail <= cyc;

        check("req_ready", req_ready, eready);
        check("core_state", core_state, es);
        check("core_key", core_key, ek);
        check("rsp_valid", rsp_valid, erv);
        check("busy", busy, !rst && mq.size() != 0);
        if (erv) begin
            check("rsp_data", rsp_data, mq[0].data);
            check("rsp_id", rsp_id, mq[0].id);
        end
        check("fifo_no_overflow",
              ((dut.count_q == DEPTH) && dut.vld_q[LATENCY-1] && !(rsp_valid && rsp_ready)) === 1'b1, 0);
`ifdef AES128_SCHED_STATS_EN
        if (!rst) begin
            check("stat_issued", stat_issued, m_iss);
            check("stat_stall", stat_stall, m_stall);
        end
`endif
        if (rst) begin
            mq.delete();
            m_last  = N - 1;
            m_iss   = 0;
            m_stall = 0;
        end else begin
            if ((|req_valid) && mq.size() == DEPTH) m_stall++;
            if (erv && rsp_ready) void'(mq.pop_front());
            if (eg) begin
                mq.push_back('{IDW'(egi), aes_enc(es, ek), cyc + LATENCY + 1});
                m_last = egi;
                m_iss++;
            end
        end
        cyc++;
    end

    // ---------------- Stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_state[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            req_key[128*i +: 128]   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic test_single();
        int  lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        req_state[127:0] = PT_C1;
        req_key[127:0]   = KEY_C1;
        req_valid        = 2'b01;
        @(negedge clk);
        check("single_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        for (int i = 1; i <= 100; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            step();
        end
        check("single_seen", seen, 1);
        check("single_latency", lat, LATENCY + 1);
        check("single_data", rsp_data, CT_C1);
        check("single_id", rsp_id, 0);
        check("single_busy", busy, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("single_busy_after_pop", busy, 0);
        check("single_empty_after_pop", rsp_valid, 0);
    endtask

    task automatic test_rr();
        logic [N-1:0]   g [6];
        logic [IDW-1:0] ids [6];
        logic [127:0]   dat [6];
        int got;
        got = 0;
        req_state[127:0]   = PT_C1;
        req_key[127:0]     = KEY_C1;
        req_state[255:128] = PT_B;
        req_key[255:128]   = KEY_B;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g[k] = req_ready;
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 100 && got < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ids[got] = rsp_id;
                dat[got] = rsp_data;
                got++;
            end
            step();
        end
        check("rr_count", got, 6);
        for (int k = 0; k < 6; k++) begin
            check("rr_grant", g[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k < got) begin
                check("rr_id", ids[k], k % 2);
                check("rr_data", dat[k], (k % 2 == 0) ? CT_C1 : CT_B);
            end
        end
    endtask

    task automatic test_bp();
        int acc, run;
        acc = 0;
        run = 0;
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        rand_data();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            step();
            rand_data();
        end
        check("bp_accepts", acc, DEPTH);
        check("bp_ready_low", req_ready, 0);
`ifdef AES128_SCHED_STATS_EN
        check("bp_stat_issued", stat_issued, 32);
        check("bp_stat_stall", stat_stall, 60 - DEPTH);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_issue_at_full", req_ready, 0);
        step();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready[0]) run++;
            step();
            rand_data();
        end
        check("bp_sustained_issue", run, 100);
        req_valid = '0;
        for (int c = 0; c < 200 && busy; c++) step();
        check("bp_drained", busy, 0);
    endtask

    task automatic test_rst_mid();
        logic anyv;
        anyv = 1'b0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 26; c++) begin
            req_valid = (c < 5) ? 2'b01 : ((c >= 12 && c < 22) ? 2'b11 : 2'b00);
            rand_data();
            if (c == 25) begin
                @(negedge clk);
                check("mid_buffered", rsp_valid, 1);
                check("mid_busy", busy, 1);
            end
            step();
        end
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        check("mid_rsp_valid_cleared", rsp_valid, 0);
        check("mid_busy_cleared", busy, 0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) anyv = 1'b1;
            step();
        end
        check("mid_no_late_rsp", anyv, 0);
        req_valid = 2'b11;
        @(negedge clk);
        check("mid_first_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
    endtask

    task automatic test_random();
        int mode;
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 3);
            req_valid = N'($urandom);
            rand_data();
            case (mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = ($urandom_range(0, 3) == 0);
                2:       rsp_ready = ($urandom_range(0, 1) == 0);
                default: rsp_ready = 1'b1;
            endcase
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && busy; c++) step();
        check("final_drained", busy, 0);
    endtask

    initial begin
        build_sbox();
        rst       = 1'b1;
        req_valid = '0;
        req_state = '0;
        req_key   = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_req_ready", req_ready, 0);
        rst = 1'b0;
        check("aes_model_c1", aes_enc(PT_C1, KEY_C1), CT_C1);
        check("aes_model_b", aes_enc(PT_B, KEY_B), CT_B);
        test_single();
        do_reset();
        test_rr();
        do_reset();
        test_bp();
        do_reset();
        test_rst_mid();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
